lisp_heap_mem: RTL

Multi-port, parametrised heap memory for the Lisp machine: one single-ported block RAM shared by `NumPorts` requestors (evaluator, GC, loader, …) through a round-robin arbiter. It supports reads and writes, and adds a bump allocator that hands out consecutive heap cells starting at `HeapStart`. It sits between the evaluator/GC datapaths and the RAM, and holds the NIL cell and boot image at the bottom of memory.

---
 rtl/lisp_defs.sv | 23 ++
 rtl/lisp_heap_mem_if.sv | 38 +++
 rtl/lisp_heap_mem_arbiter.sv | 42 ++++
 rtl/lisp_heap_mem.sv | 136 +++++++++++++
 4 files changed

// File: rtl/lisp_defs.sv
// lisp_defs: shared constants for the Lisp machine datapath.
// Holds the cell type tags, the NIL cell encoding and the first
// allocatable heap cell. There are no ports; other files import it
// with "import lisp_defs::*".
package lisp_defs;

  localparam int LISP_WORD = 16;

  // The top three bits of a cell carry its type tag.
  typedef enum logic [2:0] {
    TAG_INT  = 3'd0,
    TAG_CONS = 3'd1,
    TAG_SYM  = 3'd2,
    TAG_FUNC = 3'd3,
    TAG_NIL  = 3'd7
  } lisp_tag_e;

  localparam logic [LISP_WORD-1:0] LISP_NIL = {TAG_NIL, 13'h0000};

  // Cells 0..HEAP_START-1 hold NIL and the boot image.
  localparam int HEAP_START = 5;

endpackage

// File: rtl/lisp_heap_mem_if.sv
// lisp_heap_mem_if: request bus between the requestors (evaluator, GC,
// loader, ...) and the shared heap memory.
//   req/we/addr/wdata  per-port access request (master -> slave)
//   gnt/data_ready/rdata  per-port grant and completion (slave -> master)
//   alloc_req/alloc_len  bump-allocation request (master -> slave)
//   alloc_done/alloc_addr/alloc_oom/free_ptr  allocation result (slave -> master)
interface lisp_heap_mem_if #(
  parameter int NumPorts  = 2,
  parameter int AddrWidth = 8,
  parameter int DataWidth = 16
);

  logic [NumPorts-1:0]                req;
  logic [NumPorts-1:0]                we;
  logic [NumPorts-1:0][AddrWidth-1:0] addr;
  logic [NumPorts-1:0][DataWidth-1:0] wdata;
  logic [NumPorts-1:0]                gnt;
  logic [NumPorts-1:0]                data_ready;
  logic [NumPorts-1:0][DataWidth-1:0] rdata;

  logic                 alloc_req;
  logic [AddrWidth-1:0] alloc_len;
  logic                 alloc_done;
  logic [AddrWidth-1:0] alloc_addr;
  logic                 alloc_oom;
  logic [AddrWidth-1:0] free_ptr;

  modport master (
    output req, we, addr, wdata, alloc_req, alloc_len,
    input  gnt, data_ready, rdata, alloc_done, alloc_addr, alloc_oom, free_ptr
  );

  modport slave (
    input  req, we, addr, wdata, alloc_req, alloc_len,
    output gnt, data_ready, rdata, alloc_done, alloc_addr, alloc_oom, free_ptr
  );

endinterface

// File: rtl/lisp_heap_mem_arbiter.sv
// rr_arbiter: round-robin arbiter for N requestors.
//   clk, rst  clock and synchronous active-high reset
//   req       per-requestor request
//   gnt       combinational one-hot grant, all zero while rst is high
// The search starts at the rr pointer; after granting port i the pointer
// moves to (i+1) mod N, and it stays put on idle cycles.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [PW-1:0] r_rr;
  logic [PW-1:0] w_nextRr;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    gnt      = '0;
    w_nextRr = r_rr;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(r_rr) + k) % N);
      if (!rst && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
        w_nextRr   = PW'((int'(w_idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_rr <= '0;
    else     r_rr <= w_nextRr;
  end

endmodule

// File: rtl/lisp_heap_mem.sv
// lisp_heap_mem: single-ported heap RAM shared by NumPorts requestors
// through a round-robin arbiter, plus a bump allocator.
//   clk, rst  clock and synchronous active-high reset
//   bus       lisp_heap_mem_if slave: per-port req/we/addr/wdata in,
//             gnt/data_ready/rdata out; alloc_req/alloc_len in,
//             alloc_done/alloc_addr/alloc_oom/free_ptr out
// Memory contents survive reset. With no InitFile, cell 0 holds NIL and
// every other cell is zero.
module lisp_heap_mem
  import lisp_defs::*;
#(
  parameter  int    DataWidth = 16,
  parameter  int    Depth     = 256,
  parameter  int    NumPorts  = 2,
  parameter  int    HeapStart = HEAP_START,
  parameter  string InitFile  = "",
  localparam int    AddrWidth = $clog2(Depth),
  localparam int    PortWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input logic            clk,
  input logic            rst,
  lisp_heap_mem_if.slave bus
);

  (* ram_style = "block" *)
  logic [DataWidth-1:0] r_mem [Depth] = '{0: DataWidth'(LISP_NIL), default: '0};

  logic [NumPorts-1:0]                w_gnt;
  logic [PortWidth-1:0]               w_sel;
  logic                               w_any;
  logic [AddrWidth-1:0]               w_addr;
  logic                               w_we;
  logic [DataWidth-1:0]               r_ramOut;
  logic [NumPorts-1:0]                r_ready;
  logic                               r_wasRead;
  logic [PortWidth-1:0]               r_port;
  logic [NumPorts-1:0][DataWidth-1:0] r_hold;

  rr_arbiter #(.N(NumPorts)) u_arbiter (
    .clk (clk),
    .rst (rst),
    .req (bus.req),
    .gnt (w_gnt)
  );

  assign bus.gnt = w_gnt;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (w_gnt[i]) w_sel = PortWidth'(i);
    end
  end

  assign w_any  = |w_gnt;
  assign w_addr = bus.addr[w_sel];
  assign w_we   = bus.we[w_sel];

  // Plain single-port RAM: no reset, so it maps onto a block RAM. The
  // arbiter holds gnt low during rst, which drops accesses in that cycle.
  always_ff @(posedge clk) begin
    if (w_any) begin
      if (w_we) r_mem[w_addr] <= bus.wdata[w_sel];
      else      r_ramOut      <= r_mem[w_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready   <= '0;
      r_wasRead <= 1'b0;
      r_port    <= '0;
    end else begin
      r_ready   <= w_gnt;
      r_wasRead <= w_any & ~w_we;
      r_port    <= w_sel;
    end
  end

  // The RAM output register is shared by all ports, so each port keeps its
  // last read value in its own hold register, captured one cycle later.
  always_ff @(posedge clk) begin
    if (rst)            r_hold         <= '0;
    else if (r_wasRead) r_hold[r_port] <= r_ramOut;
  end

  // In the completion cycle of a read, bypass the RAM output straight to the
  // port so rdata is valid together with data_ready.
  always_comb begin
    bus.rdata = r_hold;
    for (int i = 0; i < NumPorts; i++) begin
      if (r_wasRead && r_port == PortWidth'(i)) bus.rdata[i] = r_ramOut;
    end
  end

  assign bus.data_ready = r_ready;

  logic [AddrWidth-1:0] r_freePtr;
  logic [AddrWidth-1:0] r_allocAddr;
  logic                 r_allocDone;
  logic                 r_allocOom;
  logic [AddrWidth:0]   w_sum;
  logic                 w_fits;

  // One extra bit so a block ending exactly at Depth still fits; free_ptr
  // then wraps to zero.
  assign w_sum  = {1'b0, r_freePtr} + {1'b0, bus.alloc_len};
  assign w_fits = (w_sum <= (AddrWidth + 1)'(Depth));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_freePtr   <= AddrWidth'(HeapStart);
      r_allocAddr <= '0;
      r_allocDone <= 1'b0;
      r_allocOom  <= 1'b0;
    end else begin
      r_allocDone <= bus.alloc_req;
      r_allocOom  <= 1'b0;
      if (bus.alloc_req) begin
        if (w_fits) begin
          r_allocAddr <= r_freePtr;
          r_freePtr   <= w_sum[AddrWidth-1:0];
        end else begin
          r_allocAddr <= '0;
          r_allocOom  <= 1'b1;
        end
      end
    end
  end

  assign bus.alloc_done = r_allocDone;
  assign bus.alloc_addr = r_allocAddr;
  assign bus.alloc_oom  = r_allocOom;
  assign bus.free_ptr   = r_freePtr;

endmodule
